serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract engine built around one shared 1-bit full-adder/full-subtractor cell.
- Accepts a WIDTH-bit operand pair and an op code through a valid/ready handshake.
- Sequences the cell LSB-first over WIDTH cycles, then presents the result, carry/borrow and signed overflow through a valid/ready output handshake.
- Used where area matters more than latency; the single cell is time-shared across all bit positions.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit-position counter (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  block can accept a new operation (high only in IDLE).
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a_in  input  WIDTH  operand A (minuend for subtract).
- b_in  input  WIDTH  operand B (subtrahend for subtract).
- out_valid  output  1  result fields valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  (a+b) or (a-b) mod 2^WIDTH.
- cout  output  1  final carry (add) or final borrow (sub); borrow = 1 iff a < b unsigned.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - result, cout, ovf, out_valid, busy = 0; in_ready = 1 the following cycle.
  - Counter, shift registers and the carry/borrow register are cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_in, b_in, op into shift registers; cnt=0; cy=0; state→RUN.
- RUN:
  - in_ready=0; in_valid is ignored, and operand inputs may change without effect.
  - Each edge processes bit cnt using the LSBs of the A/B shift registers and cy:
    - add: s=a^b^cy; cy'=(a&b)|(a&cy)|(b&cy).
    - sub: d=a^b^cy; cy'=(~a&b)|(~(a^b)&cy).
  - The result bit shifts in at the MSB of the result shift register (right shift); the A/B registers shift right; cnt increments.
  - At the edge processing cnt==WIDTH-1:
    - cout=cy'.
    - ovf = cy (carry/borrow into the MSB) XOR cy'.
    - state→DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge (8 for the default WIDTH).
- DONE:
  - out_valid=1; result, cout, ovf are held stable until the handshake completes.
  - On out_ready: state→IDLE, and out_valid drops at that edge.
  - in_ready rises the cycle after the handshake; there is no same-cycle re-accept.
  - out_ready low stalls indefinitely with outputs stable.
  - out_ready while not in DONE has no effect.
- result/cout/ovf retain their last values in IDLE. They may be overwritten progressively during RUN; the consumer must sample them only when out_valid=1.
- Arithmetic is unsigned modulo 2^WIDTH. The subtract borrow uses the correct borrow equation above; a borrow in is never taken from outside (cy starts at 0).
- Counter wrap: cnt never exceeds WIDTH-1; it is reset to 0 on accept.

Decomposition:
- Shared package addsub_pkg:
  - state enum (IDLE/RUN/DONE).
  - op encoding constants OP_ADD=1'b0 and OP_SUB=1'b1.
- One natural sub-module: addsub_bit_cell.
  - Combinational; inputs a, b, cy_in, op; outputs r, cy_out.
  - Implements the add and sub equations above.
  - Instantiated once and time-shared by the controller.

Test Plan:
- WIDTH=8, add 0x3C+0x5A -> after 8 edges: result=0x96, cout=0, ovf=1, busy=1 throughout.
- Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0; sub 0x10-0x20 -> result=0xF0, cout(borrow)=1, ovf=0.
- Sub 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable. Toggle in_valid with new operands during RUN/DONE -> ignored, in_ready=0. Release out_ready -> in_ready=1 next cycle.
- Reset mid-operation: assert rst at RUN cycle 3 for one edge -> state IDLE, out_valid=0, result=0, in_ready=1. The next op 0x01+0x01 returns 0x02 after 8 edges.
- Back-to-back throughput: two ops with in_valid held high and out_ready tied 1 -> second accept exactly 2 edges after first out_valid edge; both results correct.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package addsub_pkg;

    // Controller states; explicit encoding keeps the state register two bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select encoding.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor, time-shared across all bit positions.
module addsub_bit_cell
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cy_in,
    input  logic op,
    output logic r,
    output logic cy_out
);

    // Sum and difference bits are the same XOR; only the carry/borrow differs.
    assign r = a ^ b ^ cy_in;

    // Carry out for add, borrow out for subtract.
    assign cy_out = (op == OP_SUB) ? ((~a & b) | (~(a ^ b) & cy_in))
                                   : ((a & b) | (a & cy_in) | (b & cy_in));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: accepts an operand pair, walks the single
// bit cell LSB-first over WIDTH cycles, then holds the result until consumed.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   r_sr;
    logic [CNT_W-1:0]   cnt;
    logic               op_r;
    logic               cy;
    logic               cout_r;
    logic               ovf_r;
    logic               cell_r;
    logic               cell_cy;
    logic               last_bit;

    // The one shared arithmetic cell always looks at the current LSBs.
    addsub_bit_cell u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .cy_in  (cy),
        .op     (op_r),
        .r      (cell_r),
        .cy_out (cell_cy)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Controller, operand/result shifting and final flag capture.
    // NOTE: all state here uses <= so every register samples pre-edge values;
    // blocking assignments would let the shift chain ripple within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            cnt    <= '0;
            op_r   <= OP_ADD;
            cy     <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        op_r  <= op;
                        cnt   <= '0;
                        cy    <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    r_sr <= {cell_r, r_sr[WIDTH-1:1]};
                    cy   <= cell_cy;
                    if (last_bit) begin
                        // Overflow: carry into the MSB differs from carry out of it.
                        cout_r <= cell_cy;
                        ovf_r  <= cy ^ cell_cy;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = r_sr;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8) with an arithmetic model.
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, not bit-serial.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic o,
                                  output logic [7:0] r, output logic c, output logic v);
        int unsigned ua = a;
        int unsigned ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int s;
        if (!o) begin
            r = 8'(ua + ub);
            c = (ua + ub) > 255;
            s = sa + sb;
        end else begin
            r = 8'(ua - ub);
            c = ua < ub;
            s = sa - sb;
        end
        v = (s > 127) || (s < -128);
    endfunction

    // Runs one operation through both handshakes and reports what it saw.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic o,
                          output logic [7:0] r, output logic c, output logic v,
                          output int lat, output logic busy_ok);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        op = o;
        tick();
        in_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        op = 1'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            busy_ok &= busy & ~in_ready;
            tick();
            lat++;
        end
        busy_ok &= busy;
        r = result;
        c = cout;
        v = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 1'b0;
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, busy, result, cout, ovf} !== {3'b100, 8'h00, 2'b00})
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b res=%h c=%b v=%b expected rdy=1 vld=0 busy=0 res=00 c=0 v=0",
                     in_ready, out_valid, busy, result, cout, ovf);
        else pass_cnt++;
        // out_ready outside DONE must not disturb IDLE.
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL idle_out_ready: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [7:0] va [4] = '{8'h3C, 8'hFF, 8'h10, 8'h80};
        logic [7:0] vb [4] = '{8'h5A, 8'h01, 8'h20, 8'h01};
        logic       vo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] r, er;
        logic c, v, ec, ev, bok;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vo[i], r, c, v, lat, bok);
            model(va[i], vb[i], vo[i], er, ec, ev);
            total_cnt++;
            if ({r, c, v} !== {er, ec, ev})
                $display("FAIL directed_%0d: got res=%h c=%b v=%b expected res=%h c=%b v=%b", i, r, c, v, er, ec, ev);
            else pass_cnt++;
            total_cnt++;
            if (lat !== WIDTH)
                $display("FAIL latency_%0d: got %0d edges expected %0d", i, lat, WIDTH);
            else pass_cnt++;
            total_cnt++;
            if (bok !== 1'b1)
                $display("FAIL busy_during_run_%0d: got %b expected 1", i, bok);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] r, er;
        logic c, v, ec, ev;
        logic rdy_low, stable;
        int guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        a_in = 8'h3C;
        b_in = 8'h5A;
        op = 1'b0;
        tick();
        rdy_low = 1'b1;
        guard = 0;
        while (!out_valid && guard < 20) begin
            in_valid = ~in_valid;
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            op = 1'($urandom);
            rdy_low &= ~in_ready;
            tick();
            guard++;
        end
        r = result;
        c = cout;
        v = ovf;
        model(8'h3C, 8'h5A, 1'b0, er, ec, ev);
        total_cnt++;
        if ({out_valid, r, c, v} !== {1'b1, er, ec, ev})
            $display("FAIL bp_result: got vld=%b res=%h c=%b v=%b expected vld=1 res=%h c=%b v=%b",
                     out_valid, r, c, v, er, ec, ev);
        else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            tick();
            stable &= out_valid & ~in_ready & (result == r) & (cout == c) & (ovf == v);
            rdy_low &= ~in_ready;
        end
        total_cnt++;
        if (stable !== 1'b1)
            $display("FAIL bp_stall_stable: got %b expected 1", stable);
        else pass_cnt++;
        total_cnt++;
        if (rdy_low !== 1'b1)
            $display("FAIL bp_in_ready_low: got %b expected 1", rdy_low);
        else pass_cnt++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL bp_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] r;
        logic c, v, bok, seen_valid;
        int lat;
        in_valid = 1'b1;
        a_in = 8'h3C;
        b_in = 8'h5A;
        op = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, busy, result, cout, ovf} !== {3'b100, 8'h00, 2'b00})
            $display("FAIL mid_reset_state: got rdy=%b vld=%b busy=%b res=%h c=%b v=%b expected 1 0 0 00 0 0",
                     in_ready, out_valid, busy, result, cout, ovf);
        else pass_cnt++;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_valid |= out_valid;
        end
        total_cnt++;
        if (seen_valid !== 1'b0)
            $display("FAIL mid_reset_no_result: got out_valid=%b expected 0", seen_valid);
        else pass_cnt++;
        run_op(8'h01, 8'h01, 1'b0, r, c, v, lat, bok);
        total_cnt++;
        if ({r, c, v, lat} !== {8'h02, 1'b0, 1'b0, WIDTH})
            $display("FAIL post_reset_op: got res=%h c=%b v=%b lat=%0d expected res=02 c=0 v=0 lat=%0d",
                     r, c, v, lat, WIDTH);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int edge_n = 0;
        int acc [$];
        int ovr [$];
        logic [7:0] res [$];
        logic [1:0] flg [$];
        logic prev_ov, will_acc;
        logic [7:0] e0, e1;
        logic c0, v0, c1, v1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a_in = 8'h12;
        b_in = 8'h34;
        op = 1'b0;
        prev_ov = out_valid;
        for (int i = 0; i < 60 && res.size() < 2; i++) begin
            will_acc = in_valid & in_ready;
            tick();
            edge_n++;
            if (will_acc) begin
                acc.push_back(edge_n);
                if (acc.size() == 1) begin
                    a_in = 8'hA0;
                    b_in = 8'h30;
                    op = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && !prev_ov) begin
                ovr.push_back(edge_n);
                res.push_back(result);
                flg.push_back({cout, ovf});
            end
            prev_ov = out_valid;
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if (acc.size() !== 2 || res.size() !== 2)
            $display("FAIL b2b_count: got accepts=%0d results=%0d expected 2 2", acc.size(), res.size());
        else begin
            pass_cnt++;
            model(8'h12, 8'h34, 1'b0, e0, c0, v0);
            model(8'hA0, 8'h30, 1'b1, e1, c1, v1);
            total_cnt++;
            if (acc[1] - ovr[0] !== 2)
                $display("FAIL b2b_gap: got %0d edges expected 2", acc[1] - ovr[0]);
            else pass_cnt++;
            total_cnt++;
            if (ovr[0] - acc[0] !== WIDTH || ovr[1] - acc[1] !== WIDTH)
                $display("FAIL b2b_latency: got %0d,%0d expected %0d", ovr[0] - acc[0], ovr[1] - acc[1], WIDTH);
            else pass_cnt++;
            total_cnt++;
            if ({res[0], flg[0]} !== {e0, c0, v0})
                $display("FAIL b2b_first: got res=%h cv=%b expected res=%h cv=%b%b", res[0], flg[0], e0, c0, v0);
            else pass_cnt++;
            total_cnt++;
            if ({res[1], flg[1]} !== {e1, c1, v1})
                $display("FAIL b2b_second: got res=%h cv=%b expected res=%h cv=%b%b", res[1], flg[1], e1, c1, v1);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, r, er;
        logic o, c, v, ec, ev, bok;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            o = 1'($urandom);
            run_op(a, b, o, r, c, v, lat, bok);
            model(a, b, o, er, ec, ev);
            total_cnt++;
            if ({r, c, v, lat} !== {er, ec, ev, WIDTH})
                $display("FAIL random_%0d (%h %s %h): got res=%h c=%b v=%b lat=%0d expected res=%h c=%b v=%b lat=%0d",
                         i, a, o ? "-" : "+", b, r, c, v, lat, er, ec, ev, WIDTH);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
